// File: rtl/servant_spi_bus_arbiter_pkg.sv
// Shared constants for the SPI RAM bus arbiter: FSM state codes and the full byte-enable mask.
package servant_spi_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LAUNCH  = 3'd1;
    localparam logic [2:0] ST_BUSY    = 3'd2;
    localparam logic [2:0] ST_RESP    = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;

    localparam logic [3:0] SPI_SEL_FULL = 4'hF;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/servant_spi_bus_arbiter_if.sv
// Bundle of the ibus, dbus and downstream SPI master Wishbone signals around the arbiter.
// The master modport is the arbiter's view; the slave modport is the CPU/SPI-master side.
interface servant_spi_bus_arbiter_if #(
    parameter int ADDRESS_WIDTH = 24
) ();
    import servant_spi_pkg::*;

    logic [ADDRESS_WIDTH-3:0] i_ibus_adr;
    logic                     i_ibus_cyc;
    word_t                    o_ibus_rdt;
    logic                     o_ibus_ack;

    logic [ADDRESS_WIDTH-3:0] i_dbus_adr;
    word_t                    i_dbus_dat;
    logic [3:0]               i_dbus_sel;
    logic                     i_dbus_we;
    logic                     i_dbus_cyc;
    word_t                    o_dbus_rdt;
    logic                     o_dbus_ack;

    logic [ADDRESS_WIDTH-3:0] o_spi_adr;
    word_t                    o_spi_dat;
    logic [3:0]               o_spi_sel;
    logic                     o_spi_we;
    logic                     o_spi_cyc;
    word_t                    i_spi_rdt;
    logic                     i_spi_ack;

    modport master (
        input  i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we,
               i_dbus_cyc, i_spi_rdt, i_spi_ack,
        output o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack,
               o_spi_adr, o_spi_dat, o_spi_sel, o_spi_we, o_spi_cyc
    );

    modport slave (
        output i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we,
               i_dbus_cyc, i_spi_rdt, i_spi_ack,
        input  o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack,
               o_spi_adr, o_spi_dat, o_spi_sel, o_spi_we, o_spi_cyc
    );

endinterface

// File: rtl/servant_spi_bus_arbiter_rr_arb.sv
// Two-way round-robin picker between ibus and dbus; purely combinational, pointer held by parent.
// Zero latency; on a tie the requester not served last wins.
module servant_spi_rr_arb (
    input  logic ibus_cyc,
    input  logic dbus_cyc,
    input  logic last_dbus,
    output logic grant_valid,
    output logic grant_dbus
);

    assign grant_valid = ibus_cyc | dbus_cyc;
    assign grant_dbus  = dbus_cyc & (~ibus_cyc | ~last_dbus);

endmodule

// File: rtl/servant_spi_bus_arbiter.sv
// Shares one SPI RAM Wishbone master between SERV ibus and dbus, one registered request at a time.
// Upstream latency = downstream busy time + 3 cycles; requesters stall on cyc until their ack pulse.
module servant_spi_bus_arbiter
    import servant_spi_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 24
) (
    input  logic                    clock,
    input  logic                    reset_n,
    servant_spi_bus_arbiter_if.master bus,
    output logic                    o_grant_dbus,
    output logic                    o_busy
);

    logic [2:0]               state;
    logic                     last_dbus;
    logic                     grant_dbus;
    logic [ADDRESS_WIDTH-3:0] spi_adr;
    word_t                    spi_dat;
    logic [3:0]               spi_sel;
    logic                     spi_we;
    word_t                    ibus_rdt;
    word_t                    dbus_rdt;

    logic                     arb_vld;
    logic                     arb_dbus;

    servant_spi_rr_arb u_arb (
        .ibus_cyc    (bus.i_ibus_cyc),
        .dbus_cyc    (bus.i_dbus_cyc),
        .last_dbus   (last_dbus),
        .grant_valid (arb_vld),
        .grant_dbus  (arb_dbus)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_dbus  <= 1'b1;
            grant_dbus <= 1'b0;
            spi_adr    <= '0;
            spi_dat    <= '0;
            spi_sel    <= '0;
            spi_we     <= 1'b0;
            ibus_rdt   <= '0;
            dbus_rdt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        state      <= ST_LAUNCH;
                        grant_dbus <= arb_dbus;
                        last_dbus  <= arb_dbus;
                        if (arb_dbus) begin
                            spi_adr <= bus.i_dbus_adr;
                            spi_dat <= bus.i_dbus_dat;
                            spi_sel <= bus.i_dbus_sel;
                            spi_we  <= bus.i_dbus_we;
                        end else begin
                            spi_adr <= bus.i_ibus_adr;
                            spi_dat <= '0;
                            spi_sel <= SPI_SEL_FULL;
                            spi_we  <= 1'b0;
                        end
                    end
                end
                // The SPI master's idle ack is still high here, so it is not sampled.
                ST_LAUNCH: state <= ST_BUSY;
                ST_BUSY: begin
                    if (bus.i_spi_ack) begin
                        state <= ST_RESP;
                        if (grant_dbus) dbus_rdt <= bus.i_spi_rdt;
                        else            ibus_rdt <= bus.i_spi_rdt;
                    end
                end
                ST_RESP:    state <= ST_HOLDOFF;
                ST_HOLDOFF: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // cyc drops in the ack cycle itself so the SPI master never sees cyc while it is idle again.
    assign bus.o_spi_cyc  = (state == ST_LAUNCH) | ((state == ST_BUSY) & ~bus.i_spi_ack);
    assign bus.o_spi_adr  = spi_adr;
    assign bus.o_spi_dat  = spi_dat;
    assign bus.o_spi_sel  = spi_sel;
    assign bus.o_spi_we   = spi_we;

    assign bus.o_ibus_ack = (state == ST_RESP) & ~grant_dbus;
    assign bus.o_dbus_ack = (state == ST_RESP) &  grant_dbus;
    assign bus.o_ibus_rdt = ibus_rdt;
    assign bus.o_dbus_rdt = dbus_rdt;

    assign o_grant_dbus   = grant_dbus;
    assign o_busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_servant_spi_bus_arbiter.sv
// Directed bench for the SPI bus arbiter with a behavioural SPI master and request/response scoreboards.
module tb_servant_spi_bus_arbiter;

    logic clock;
    logic reset_n;
    logic o_grant_dbus;
    logic o_busy;

    servant_spi_bus_arbiter_if #(.ADDRESS_WIDTH(24)) bus ();

    servant_spi_bus_arbiter #(.ADDRESS_WIDTH(24)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .o_grant_dbus (o_grant_dbus),
        .o_busy       (o_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [21:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] rdt;
    } dn_t;

    typedef struct {
        logic        dbus;
        logic [31:0] rdt;
    } up_t;

    dn_t dn_q[$];
    up_t up_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int dn_delay = 19;
    int dn_starts = 0;
    logic dn_busy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_ibus(input logic [21:0] adr, input logic [31:0] rdt);
        dn_t d;
        up_t u;
        d.adr = adr; d.dat = 32'h0; d.sel = 4'hF; d.we = 1'b0; d.rdt = rdt;
        u.dbus = 1'b0; u.rdt = rdt;
        dn_q.push_back(d);
        up_q.push_back(u);
    endtask

    task automatic push_dbus(input logic [21:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                             input logic we, input logic [31:0] rdt);
        dn_t d;
        up_t u;
        d.adr = adr; d.dat = dat; d.sel = sel; d.we = we; d.rdt = rdt;
        u.dbus = 1'b1; u.rdt = rdt;
        dn_q.push_back(d);
        up_q.push_back(u);
    endtask

    task automatic wait_acks(input string tag, input int n, input int budget);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            @(negedge clock);
            t++;
            if (bus.o_ibus_ack || bus.o_dbus_ack) seen++;
        end
        chk(tag, seen, n);
    endtask

    // SPI master model: acks high while idle, restarts whenever it sees cyc while idle.
    initial begin : spi_model
        logic        start;
        logic [31:0] cur_rdt;
        int          cnt;
        dn_t         e;
        bus.i_spi_ack = 1'b1;
        bus.i_spi_rdt = 32'h0;
        cur_rdt = 32'h0;
        cnt = 0;
        forever begin
            @(negedge clock);
            start = 1'b0;
            if (reset_n && dn_busy && bus.i_spi_ack)
                chk("spi_cyc_low_in_ack", bus.o_spi_cyc, 1'b0);
            if (reset_n && !dn_busy && bus.o_spi_cyc) begin
                start = 1'b1;
                dn_starts++;
                if (dn_q.size() == 0) begin
                    chk("unexpected_dn_start", 1'b1, 1'b0);
                    cur_rdt = 32'h0;
                end else begin
                    e = dn_q.pop_front();
                    chk("dn_adr", bus.o_spi_adr, e.adr);
                    chk("dn_dat", bus.o_spi_dat, e.dat);
                    chk("dn_sel", bus.o_spi_sel, e.sel);
                    chk("dn_we",  bus.o_spi_we,  e.we);
                    cur_rdt = e.rdt;
                end
            end
            @(posedge clock);
            #1;
            if (!reset_n) begin
                dn_busy = 1'b0;
                bus.i_spi_ack = 1'b1;
            end else if (start) begin
                dn_busy = 1'b1;
                cnt = dn_delay;
                bus.i_spi_ack = 1'b0;
            end else if (dn_busy) begin
                if (bus.i_spi_ack) dn_busy = 1'b0;
                else if (cnt == 0) begin
                    bus.i_spi_ack = 1'b1;
                    bus.i_spi_rdt = cur_rdt;
                end else cnt--;
            end
        end
    end

    // Upstream monitor: every ack must match the scoreboard, be one cycle wide, and be followed by cyc low.
    initial begin : up_monitor
        logic prev_ack;
        int   post;
        up_t  u;
        prev_ack = 1'b0;
        post = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_ack = 1'b0;
                post = 0;
            end else begin
                if (bus.o_ibus_ack || bus.o_dbus_ack) begin
                    chk("ack_both_sides", bus.o_ibus_ack & bus.o_dbus_ack, 1'b0);
                    chk("ack_pulse_width", prev_ack, 1'b0);
                    if (up_q.size() == 0) chk("unexpected_ack", 1'b1, 1'b0);
                    else begin
                        u = up_q.pop_front();
                        chk("ack_side", bus.o_dbus_ack, u.dbus);
                        chk("ack_rdt", u.dbus ? bus.o_dbus_rdt : bus.o_ibus_rdt, u.rdt);
                    end
                    post = 2;
                end else if (post > 0) begin
                    chk("cyc_low_after_ack", bus.o_spi_cyc, 1'b0);
                    post--;
                end
                prev_ack = bus.o_ibus_ack | bus.o_dbus_ack;
            end
        end
    end

    initial begin : stimulus
        int starts_before;
        int t;
        reset_n = 1'b0;
        bus.i_ibus_adr = '0;
        bus.i_ibus_cyc = 1'b0;
        bus.i_dbus_adr = '0;
        bus.i_dbus_dat = '0;
        bus.i_dbus_sel = '0;
        bus.i_dbus_we  = 1'b0;
        bus.i_dbus_cyc = 1'b0;

        // Reset with the SPI master's idle ack high.
        repeat (3) @(negedge clock);
        chk("rst_spi_ack_high", bus.i_spi_ack, 1'b1);
        chk("rst_busy",      o_busy, 1'b0);
        chk("rst_grant",     o_grant_dbus, 1'b0);
        chk("rst_spi_cyc",   bus.o_spi_cyc, 1'b0);
        chk("rst_ibus_ack",  bus.o_ibus_ack, 1'b0);
        chk("rst_dbus_ack",  bus.o_dbus_ack, 1'b0);
        chk("rst_spi_sel",   bus.o_spi_sel, 4'h0);
        chk("rst_spi_adr",   bus.o_spi_adr, 22'h0);
        chk("rst_ibus_rdt",  bus.o_ibus_rdt, 32'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        chk("idle_busy", o_busy, 1'b0);
        chk("idle_no_ack", bus.o_ibus_ack | bus.o_dbus_ack, 1'b0);

        // Both requesters held: ibus wins the first tie, then strict alternation.
        dn_delay = 3;
        bus.i_ibus_adr = 22'h000020;
        bus.i_dbus_adr = 22'h000030;
        bus.i_dbus_dat = 32'h55AA55AA;
        bus.i_dbus_sel = 4'h3;
        bus.i_dbus_we  = 1'b0;
        push_ibus(22'h000020, 32'h10000001);
        push_dbus(22'h000030, 32'h55AA55AA, 4'h3, 1'b0, 32'h20000002);
        push_ibus(22'h000020, 32'h10000003);
        push_dbus(22'h000030, 32'h55AA55AA, 4'h3, 1'b0, 32'h20000004);
        bus.i_ibus_cyc = 1'b1;
        bus.i_dbus_cyc = 1'b1;
        wait_acks("rr_four_acks", 4, 400);
        bus.i_ibus_cyc = 1'b0;
        bus.i_dbus_cyc = 1'b0;
        chk("rr_last_grant_dbus", o_grant_dbus, 1'b1);
        repeat (4) @(negedge clock);
        chk("rr_ibus_rdt_hold", bus.o_ibus_rdt, 32'h10000003);

        // ibus read at byte address 0x40 with a slow downstream.
        dn_delay = 19;
        bus.i_ibus_adr = 22'h000010;
        push_ibus(22'h000010, 32'hDEADBEEF);
        bus.i_ibus_cyc = 1'b1;
        wait_acks("ibus_read_ack", 1, 200);
        bus.i_ibus_cyc = 1'b0;
        chk("ibus_read_grant", o_grant_dbus, 1'b0);
        repeat (4) @(negedge clock);
        chk("ibus_rdt_hold", bus.o_ibus_rdt, 32'hDEADBEEF);
        chk("dbus_rdt_untouched", bus.o_dbus_rdt, 32'h20000004);

        // dbus partial write.
        dn_delay = 4;
        bus.i_dbus_adr = 22'h000055;
        bus.i_dbus_dat = 32'h12345678;
        bus.i_dbus_sel = 4'b1100;
        bus.i_dbus_we  = 1'b1;
        push_dbus(22'h000055, 32'h12345678, 4'b1100, 1'b1, 32'h0BADF00D);
        bus.i_dbus_cyc = 1'b1;
        wait_acks("dbus_write_ack", 1, 200);
        bus.i_dbus_cyc = 1'b0;
        bus.i_dbus_dat = 32'hFFFFFFFF;
        repeat (3) @(negedge clock);

        // dbus cyc lingers one cycle after its ack; no second transfer may start.
        bus.i_dbus_adr = 22'h000066;
        bus.i_dbus_we  = 1'b0;
        bus.i_dbus_sel = 4'hF;
        push_dbus(22'h000066, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h600DCAFE);
        bus.i_dbus_cyc = 1'b1;
        wait_acks("linger_ack", 1, 200);
        starts_before = dn_starts;
        @(negedge clock);
        bus.i_dbus_cyc = 1'b0;
        repeat (10) @(negedge clock);
        chk("linger_no_restart", dn_starts, starts_before);
        chk("linger_idle", o_busy, 1'b0);

        // Reset asserted while the downstream transfer is in flight.
        dn_delay = 12;
        bus.i_ibus_adr = 22'h000077;
        push_ibus(22'h000077, 32'h11111111);
        bus.i_ibus_cyc = 1'b1;
        t = 0;
        while (!dn_busy && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("midbusy_reached", dn_busy, 1'b1);
        repeat (3) @(negedge clock);
        #2;
        reset_n = 1'b0;
        bus.i_ibus_cyc = 1'b0;
        #1;
        chk("midrst_busy",     o_busy, 1'b0);
        chk("midrst_spi_cyc",  bus.o_spi_cyc, 1'b0);
        chk("midrst_spi_adr",  bus.o_spi_adr, 22'h0);
        chk("midrst_spi_sel",  bus.o_spi_sel, 4'h0);
        chk("midrst_ibus_rdt", bus.o_ibus_rdt, 32'h0);
        chk("midrst_dbus_rdt", bus.o_dbus_rdt, 32'h0);
        up_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Recovery: a fresh ibus request completes normally.
        dn_delay = 5;
        bus.i_ibus_adr = 22'h000099;
        push_ibus(22'h000099, 32'hCAFEF00D);
        bus.i_ibus_cyc = 1'b1;
        wait_acks("recover_ack", 1, 200);
        bus.i_ibus_cyc = 1'b0;
        repeat (4) @(negedge clock);
        chk("recover_rdt_hold", bus.o_ibus_rdt, 32'hCAFEF00D);
        chk("dn_queue_drained", dn_q.size(), 0);
        chk("up_queue_drained", up_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
